// File: rtl/ahb_pkg.sv
// AHB slave shared definitions: transfer type and size encodings, response
// constants, the SRAM slave FSM state set and the byte-lane enable helper.
// No ports (package).
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } slv_state_e;

   // Little-endian byte lanes touched by an aligned transfer.
   function automatic logic [3:0] be_from(input logic [2:0] size, input logic [1:0] addr);
      logic [3:0] be;
      case (size)
         3'd0:    be = 4'b0001 << addr;
         3'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
         3'd2:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_slv_excl_mon.sv
// Single exclusive-access reservation: {valid, master, word address}.
// Ports:
//   hclk, hresetn   clock / async active-low reset
//   set             completed exclusive read: capture master + word
//   wr_commit       a write to waddr is being committed this cycle
//   master, waddr   master id and word address of the current data phase
//   match           reservation is valid and belongs to master/waddr
module ahb_slv_excl_mon
(
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        set,
   input  logic        wr_commit,
   input  logic [3:0]  master,
   input  logic [29:0] waddr,
   output logic        match
);

   logic        valid;
   logic [3:0]  rmaster;
   logic [29:0] rwaddr;

   assign match = valid & (rmaster == master) & (rwaddr == waddr);

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         valid   <= 1'b0;
         rmaster <= 4'd0;
         rwaddr  <= 30'd0;
      end else if (set) begin
         valid   <= 1'b1;
         rmaster <= master;
         rwaddr  <= waddr;
      end else if (wr_commit && valid && (rwaddr == waddr)) begin
         valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// Word-organised AHB SRAM slave with programmable wait states and the
// two-cycle ERROR response for out-of-range, oversize or misaligned accesses.
// Optional exclusive-access support when AHB_SLV_EXCL_EN is defined
// (adds hexcl, hmaster, hexokay and the reservation monitor).
// Ports: hclk/hresetn clock and async active-low reset; hsel, haddr, htrans,
// hwrite, hsize, hburst, hmastlock, hwdata, hready from the bus;
// hreadyout, hresp, hrdata back to the bus.
//
// state   | meaning
// IDLE    | no data phase pending, zero-wait OKAY
// WAIT    | good transfer accepted, hreadyout low while wcnt counts down
// DATA    | final data-phase cycle: read data out / write lanes committed
// ERR1    | first ERROR cycle, hreadyout low
// ERR2    | second ERROR cycle, hreadyout high, next address phase sampled
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int          MEM_BYTES   = 4096,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] RDATA_IDLE  = 32'h0
)
(
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic        hmastlock,
   input  logic [31:0] hwdata,
   input  logic        hready,
`ifdef AHB_SLV_EXCL_EN
   input  logic        hexcl,
   input  logic [3:0]  hmaster,
   output logic        hexokay,
`endif
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata
);

   localparam int         DEPTH   = MEM_BYTES / 4;
   localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   slv_state_e    state, state_nxt;
   logic [3:0]    wcnt, wcnt_nxt;
   logic          load;
   logic [31:0]   addr_q;
   logic          write_q;
   logic [2:0]    size_q;
   logic [31:0]   mem [DEPTH];
   logic          accept, err_det, commit;
   logic [IW-1:0] widx;
   logic [3:0]    be;
   logic          unused_ok;

   assign unused_ok = ^{hburst, hmastlock, htrans[0]};

   assign accept  = hsel & hready & htrans[1];
   assign err_det = (haddr >= 32'(MEM_BYTES)) | (hsize > 3'd2)
                  | ((hsize == HSIZE_HALF) & haddr[0])
                  | ((hsize == HSIZE_WORD) & (haddr[1:0] != 2'b00));

   assign widx = IW'(addr_q[31:2]);
   assign be   = be_from(size_q, addr_q[1:0]);

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state   <= ST_IDLE;
         wcnt    <= 4'd0;
         addr_q  <= 32'd0;
         write_q <= 1'b0;
         size_q  <= 3'd0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (load) begin
            addr_q  <= haddr;
            write_q <= hwrite;
            size_q  <= hsize;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      load      = 1'b0;
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      case (state)
         ST_WAIT: begin
            hreadyout = 1'b0;
            if (wcnt == 4'd0) state_nxt = ST_DATA;
            else              wcnt_nxt  = wcnt - 4'd1;
         end
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
            state_nxt = ST_ERR2;
         end
         default: begin
            // IDLE, DATA and ERR2 all complete on this edge and sample the
            // next address phase, so pipelined transfers need no gap.
            if (state == ST_ERR2) hresp = HRESP_ERROR;
            state_nxt = ST_IDLE;
            if (accept) begin
               load = 1'b1;
               if (err_det) begin
                  state_nxt = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_nxt = ST_WAIT;
                  wcnt_nxt  = WS_LOAD;
               end else begin
                  state_nxt = ST_DATA;
               end
            end
         end
      endcase
   end

`ifdef AHB_SLV_EXCL_EN
   logic       excl_q;
   logic [3:0] master_q;
   logic       excl_match;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         excl_q   <= 1'b0;
         master_q <= 4'd0;
      end else if (load) begin
         excl_q   <= hexcl;
         master_q <= hmaster;
      end
   end

   ahb_slv_excl_mon u_excl_mon (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .set       ((state == ST_DATA) & ~write_q & excl_q),
      .wr_commit (commit),
      .master    (master_q),
      .waddr     (addr_q[31:2]),
      .match     (excl_match)
   );

   // A failing exclusive write still completes OKAY, it just never lands.
   assign commit  = (state == ST_DATA) & write_q & (~excl_q | excl_match);
   assign hexokay = (state == ST_DATA) & excl_q & (~write_q | excl_match);
`else
   assign commit  = (state == ST_DATA) & write_q;
`endif

   always_ff @(posedge hclk) begin
      if (commit) begin
         for (int n = 0; n < 4; n++) begin
            if (be[n]) mem[widx][8*n +: 8] <= hwdata[8*n +: 8];
         end
      end
   end

   assign hrdata = ((state == ST_DATA) && !write_q) ? mem[widx] : RDATA_IDLE;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: two instances (0 and 3 wait states),
// a pipelined AHB driver and a byte-array reference memory.
module tb_ahb_sram_slave;

   logic hclk = 1'b0;
   always #5 hclk = ~hclk;

   logic        hresetn   [2];
   logic        hsel      [2];
   logic [31:0] haddr     [2];
   logic [1:0]  htrans    [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic [31:0] hwdata    [2];
   logic        hreadyout [2];
   logic        hresp     [2];
   logic [31:0] hrdata    [2];
`ifdef AHB_SLV_EXCL_EN
   logic        hexcl     [2];
   logic [3:0]  hmaster   [2];
   logic        hexokay   [2];
`endif

   ahb_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(0), .RDATA_IDLE(32'h0000_0000)) dut0 (
      .hclk(hclk), .hresetn(hresetn[0]), .hsel(hsel[0]), .haddr(haddr[0]),
      .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(3'd0),
      .hmastlock(1'b0), .hwdata(hwdata[0]), .hready(hreadyout[0]),
`ifdef AHB_SLV_EXCL_EN
      .hexcl(hexcl[0]), .hmaster(hmaster[0]), .hexokay(hexokay[0]),
`endif
      .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));

   ahb_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(3), .RDATA_IDLE(32'hCAFE_F00D)) dut3 (
      .hclk(hclk), .hresetn(hresetn[1]), .hsel(hsel[1]), .haddr(haddr[1]),
      .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(3'd1),
      .hmastlock(1'b0), .hwdata(hwdata[1]), .hready(hreadyout[1]),
`ifdef AHB_SLV_EXCL_EN
      .hexcl(hexcl[1]), .hmaster(hmaster[1]), .hexokay(hexokay[1]),
`endif
      .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));

   int checks   = 0;
   int failures = 0;

   logic [31:0] idle_v [2];
   int          ws_v   [2];

   // op kind: 0 = real NONSEQ, 1 = NONSEQ with hsel low, 2 = selected BUSY
   int          op_k [64];
   logic        op_w [64];
   logic [31:0] op_a [64];
   logic [2:0]  op_s [64];
   logic [31:0] op_d [64];
   logic        op_x [64];
   logic [3:0]  op_m [64];

   logic        res_done [64];
   logic [31:0] res_rd   [64];
   logic        res_rs   [64];
   logic        res_wrs  [64];
   int          res_wc   [64];
   logic        res_xo   [64];

   logic [7:0]  mb [2][4096];
   logic        mk [2][4096];
   logic        rv_v [2];
   logic [3:0]  rv_m [2];
   int          rv_w [2];

   task automatic set_op(input int i, input int k, input logic w, input logic [31:0] a,
                         input logic [2:0] s, input logic [31:0] dat, input logic x, input logic [3:0] m);
      op_k[i] = k; op_w[i] = w; op_a[i] = a; op_s[i] = s; op_d[i] = dat; op_x[i] = x; op_m[i] = m;
   endtask

   task automatic drive_addr(input int d, input int idx, input int n);
      if (idx < n) begin
         hsel[d]   = (op_k[idx] != 1);
         htrans[d] = (op_k[idx] == 2) ? 2'd1 : 2'd2;
         haddr[d]  = op_a[idx];
         hwrite[d] = op_w[idx];
         hsize[d]  = op_s[idx];
`ifdef AHB_SLV_EXCL_EN
         hexcl[d]   = op_x[idx];
         hmaster[d] = op_m[idx];
`endif
      end else begin
         hsel[d]   = 1'b0;
         htrans[d] = 2'd0;
         haddr[d]  = 32'h0;
         hwrite[d] = 1'b0;
         hsize[d]  = 3'd0;
`ifdef AHB_SLV_EXCL_EN
         hexcl[d]   = 1'b0;
         hmaster[d] = 4'd0;
`endif
      end
   endtask

   // Pipelined master: the next address phase overlaps the current data phase.
   task automatic run_seq(input int d, input int n);
      int idx, dp, wc, cyc;
      logic rdy, rs, wrs, xo;
      logic [31:0] rd;
      for (int i = 0; i < n; i++) res_done[i] = 1'b0;
      idx = 0; dp = -1; wc = 0; cyc = 0; wrs = 1'b0;
      @(posedge hclk); #1;
      drive_addr(d, idx, n);
      while ((idx < n || dp >= 0) && cyc < 1000) begin
         @(negedge hclk);
         rdy = hreadyout[d]; rd = hrdata[d]; rs = hresp[d];
`ifdef AHB_SLV_EXCL_EN
         xo = hexokay[d];
`else
         xo = 1'b0;
`endif
         if (!rdy) begin
            wc++;
            wrs = wrs | rs;
            checks++;
            if (hrdata[d] !== idle_v[d]) begin
               failures++;
               $display("FAIL d%0d hrdata_idle_in_wait: got %h want %h", d, hrdata[d], idle_v[d]);
            end
         end
         @(posedge hclk);
         if (rdy) begin
            if (dp >= 0) begin
               res_done[dp] = 1'b1; res_rd[dp] = rd; res_rs[dp] = rs;
               res_wc[dp] = wc; res_wrs[dp] = wrs; res_xo[dp] = xo;
            end
            wc = 0; wrs = 1'b0;
            if (idx < n) begin dp = idx; idx++; end
            else dp = -1;
         end
         #1;
         drive_addr(d, idx, n);
         hwdata[d] = (dp >= 0) ? op_d[dp] : 32'h0;
         cyc++;
      end
      if (cyc >= 1000) begin
         checks++; failures++;
         $display("FAIL d%0d seq_timeout: got %0d cycles want < 1000", d, cyc);
      end
   endtask

   // Reference: evaluate each completed op in order against the byte model.
   task automatic check_results(input int d, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         logic        err, chk_rd, exp_xo, commit, known;
         int          exp_wc, wa, lane;
         logic [31:0] exp_rd;
         checks++;
         if (!res_done[i]) begin
            failures++;
            $display("FAIL %s[%0d] done: got 0 want 1", tag, i);
         end else begin
            err = 1'b0; chk_rd = 1'b1; exp_xo = 1'b0; exp_rd = idle_v[d]; exp_wc = 0;
            if (op_k[i] == 0) begin
               err = (op_a[i] >= 32'd4096) || (op_s[i] > 3'd2)
                  || ((op_a[i] % (32'd1 << op_s[i])) != 32'd0);
               exp_wc = err ? 1 : ws_v[d];
               if (!err) begin
                  wa = int'(op_a[i]) & ~3;
                  if (!op_w[i]) begin
                     known = 1'b1;
                     for (int b = 0; b < 4; b++) begin
                        exp_rd[8*b +: 8] = mb[d][wa+b];
                        known = known & mk[d][wa+b];
                     end
                     chk_rd = known;
                     if (op_x[i]) begin
                        rv_v[d] = 1'b1; rv_m[d] = op_m[i]; rv_w[d] = wa;
                        exp_xo = 1'b1;
                     end
                  end else begin
                     commit = !op_x[i] || (rv_v[d] && rv_m[d] == op_m[i] && rv_w[d] == wa);
                     exp_xo = op_x[i] && commit;
                     if (commit) begin
                        for (int b = 0; b < (1 << op_s[i]); b++) begin
                           lane = (int'(op_a[i]) + b) % 4;
                           mb[d][int'(op_a[i]) + b] = op_d[i][8*lane +: 8];
                           mk[d][int'(op_a[i]) + b] = 1'b1;
                        end
                        if (rv_v[d] && rv_w[d] == wa) rv_v[d] = 1'b0;
                     end
                  end
               end
            end
            if (res_rs[i] !== err) begin
               failures++;
               $display("FAIL %s[%0d] hresp: got %0b want %0b", tag, i, res_rs[i], err);
            end
            checks++;
            if (res_wc[i] != exp_wc || res_wrs[i] !== err) begin
               failures++;
               $display("FAIL %s[%0d] wait_cycles: got %0d/resp%0b want %0d/resp%0b",
                        tag, i, res_wc[i], res_wrs[i], exp_wc, err);
            end
            if (chk_rd) begin
               checks++;
               if (res_rd[i] !== exp_rd) begin
                  failures++;
                  $display("FAIL %s[%0d] hrdata: got %h want %h", tag, i, res_rd[i], exp_rd);
               end
            end
`ifdef AHB_SLV_EXCL_EN
            checks++;
            if (res_xo[i] !== exp_xo) begin
               failures++;
               $display("FAIL %s[%0d] hexokay: got %0b want %0b", tag, i, res_xo[i], exp_xo);
            end
`endif
         end
      end
   endtask

   task automatic expect_word(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         hresetn[d] = 1'b0; hwdata[d] = 32'h0;
         drive_addr(d, 0, 0);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         expect_word($sformatf("reset_hreadyout_d%0d", d), {31'd0, hreadyout[d]}, 32'd1);
         expect_word($sformatf("reset_hresp_d%0d", d), {31'd0, hresp[d]}, 32'd0);
         expect_word($sformatf("reset_hrdata_d%0d", d), hrdata[d], idle_v[d]);
`ifdef AHB_SLV_EXCL_EN
         expect_word($sformatf("reset_hexokay_d%0d", d), {31'd0, hexokay[d]}, 32'd0);
`endif
      end
      repeat (2) @(posedge hclk);
      #1;
      hresetn[0] = 1'b1; hresetn[1] = 1'b1;
   endtask

   task automatic test_ws0_basic();
      set_op(0, 0, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0, 4'd0);
      set_op(1, 0, 1'b0, 32'h10, 3'd2, 32'h0,         1'b0, 4'd0);
      set_op(2, 0, 1'b1, 32'h13, 3'd0, 32'hAA00_0000, 1'b0, 4'd0);
      set_op(3, 0, 1'b0, 32'h10, 3'd2, 32'h0,         1'b0, 4'd0);
      run_seq(0, 4);
      check_results(0, 4, "ws0_basic");
      expect_word("ws0_raw_read", res_rd[1], 32'hDEAD_BEEF);
      expect_word("ws0_byte_merge", res_rd[3], 32'hAAAD_BEEF);
   endtask

   task automatic test_wait_states();
      set_op(0, 0, 1'b1, 32'h0, 3'd2, 32'h1234_5678, 1'b0, 4'd0);
      set_op(1, 0, 1'b0, 32'h0, 3'd2, 32'h0,         1'b0, 4'd0);
      run_seq(1, 2);
      check_results(1, 2, "ws3");
      expect_word("ws3_read_waits", res_wc[1], 32'd3);
      expect_word("ws3_read_data", res_rd[1], 32'h1234_5678);
   endtask

   task automatic test_error();
      set_op(0, 0, 1'b1, 32'h20,   3'd2, 32'h1122_3344, 1'b0, 4'd0);
      set_op(1, 0, 1'b0, 32'd4096, 3'd2, 32'h0,         1'b0, 4'd0);
      set_op(2, 0, 1'b0, 32'h20,   3'd2, 32'h0,         1'b0, 4'd0);
      set_op(3, 0, 1'b1, 32'h21,   3'd1, 32'hFFFF_FFFF, 1'b0, 4'd0);
      set_op(4, 0, 1'b0, 32'h20,   3'd2, 32'h0,         1'b0, 4'd0);
      run_seq(0, 5);
      check_results(0, 5, "error");
      expect_word("err_oob_resp", {31'd0, res_rs[1]}, 32'd1);
      expect_word("err_next_in_err2", res_rd[2], 32'h1122_3344);
      expect_word("err_half_misaligned_resp", {31'd0, res_rs[3]}, 32'd1);
      expect_word("err_no_write", res_rd[4], 32'h1122_3344);
   endtask

   task automatic test_random(input int d);
      int r;
      for (int i = 0; i < 64; i++) set_op(i, 0, 1'b1, 32'(i * 4), 3'd2, $urandom, 1'b0, 4'd0);
      run_seq(d, 64);
      check_results(d, 64, $sformatf("preload_d%0d", d));
      for (int i = 0; i < 48; i++) begin
         r = $urandom_range(0, 9);
         op_k[i] = (r == 0) ? 1 : (r == 1) ? 2 : 0;
         op_w[i] = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         op_s[i] = (r < 3) ? 3'd0 : (r < 5) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
         r = $urandom_range(0, 19);
         op_a[i] = (r == 0) ? 32'd4096 + 32'($urandom_range(0, 1000))
                 : (r == 1) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 255));
         op_d[i] = $urandom;
         op_x[i] = 1'b0;
         op_m[i] = 4'd0;
      end
      run_seq(d, 48);
      check_results(d, 48, $sformatf("random_d%0d", d));
   endtask

`ifdef AHB_SLV_EXCL_EN
   task automatic test_excl();
      set_op(0, 0, 1'b0, 32'h40, 3'd2, 32'h0,         1'b1, 4'd2);
      set_op(1, 0, 1'b1, 32'h40, 3'd2, 32'h3333_3333, 1'b0, 4'd3);
      set_op(2, 0, 1'b1, 32'h40, 3'd2, 32'h2222_2222, 1'b1, 4'd2);
      set_op(3, 0, 1'b0, 32'h40, 3'd2, 32'h0,         1'b0, 4'd2);
      run_seq(0, 4);
      check_results(0, 4, "excl_broken");
      expect_word("excl_broken_okay", {31'd0, res_xo[2]}, 32'd0);
      expect_word("excl_broken_data", res_rd[3], 32'h3333_3333);
      set_op(0, 0, 1'b0, 32'h40, 3'd2, 32'h0,         1'b1, 4'd2);
      set_op(1, 0, 1'b1, 32'h40, 3'd2, 32'h4444_4444, 1'b1, 4'd2);
      set_op(2, 0, 1'b0, 32'h40, 3'd2, 32'h0,         1'b0, 4'd2);
      run_seq(0, 3);
      check_results(0, 3, "excl_ok");
      expect_word("excl_ok_okay", {31'd0, res_xo[1]}, 32'd1);
      expect_word("excl_ok_data", res_rd[2], 32'h4444_4444);
   endtask
`endif

   task automatic test_reset_mid();
      set_op(0, 0, 1'b1, 32'h80, 3'd2, 32'h55AA_55AA, 1'b0, 4'd0);
      run_seq(1, 1);
      check_results(1, 1, "rstmid_pre");
      @(posedge hclk); #1;
      set_op(0, 0, 1'b1, 32'h80, 3'd2, 32'h0BAD_F00D, 1'b0, 4'd0);
      drive_addr(1, 0, 1);
      @(posedge hclk); #1;
      drive_addr(1, 0, 0);
      hwdata[1] = 32'h0BAD_F00D;
      @(negedge hclk);
      expect_word("rstmid_in_wait", {31'd0, hreadyout[1]}, 32'd0);
      #2;
      hresetn[1] = 1'b0;
      #1;
      expect_word("rstmid_hreadyout", {31'd0, hreadyout[1]}, 32'd1);
      expect_word("rstmid_hresp", {31'd0, hresp[1]}, 32'd0);
      expect_word("rstmid_hrdata", hrdata[1], idle_v[1]);
      repeat (2) @(posedge hclk);
      #1;
      hresetn[1] = 1'b1;
      rv_v[1] = 1'b0;
      set_op(0, 0, 1'b0, 32'h80, 3'd2, 32'h0, 1'b0, 4'd0);
      run_seq(1, 1);
      check_results(1, 1, "rstmid_post");
      expect_word("rstmid_word_kept", res_rd[0], 32'h55AA_55AA);
   endtask

   initial begin
      idle_v[0] = 32'h0000_0000; idle_v[1] = 32'hCAFE_F00D;
      ws_v[0] = 0; ws_v[1] = 3;
      for (int d = 0; d < 2; d++) begin
         rv_v[d] = 1'b0; rv_m[d] = 4'd0; rv_w[d] = 0;
         for (int a = 0; a < 4096; a++) begin
            mb[d][a] = 8'h00; mk[d][a] = 1'b0;
         end
      end
      test_reset();
      test_ws0_basic();
      test_wait_states();
      test_error();
      test_random(0);
      test_random(1);
`ifdef AHB_SLV_EXCL_EN
      test_excl();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
